// File: rtl/envelope_avg_unit_if.sv
// Sample-in / envelope-out bundle between the audio front end and the envelope averager.
// The master drives samples and clear; the slave (the averager) returns the registered envelope.
interface envelope_avg_unit_if #(
  parameter int SAMPLE_WIDTH = 24
);
  logic [SAMPLE_WIDTH-1:0] sample_in;
  logic                    sample_valid;
  logic                    clear;
  logic [SAMPLE_WIDTH-1:0] env_avg;
  logic                    env_valid;
  logic                    filled;

  modport master (
    output sample_in, sample_valid, clear,
    input  env_avg, env_valid, filled
  );

  modport slave (
    input  sample_in, sample_valid, clear,
    output env_avg, env_valid, filled
  );
endinterface

// File: rtl/envelope_avg_unit.sv
// Rectified moving-average envelope over 2^LOG2_WINDOW samples, one env_valid pulse per sample.
// Two-cycle latency (rectify, then accumulate); accepts a sample every cycle, never stalls.
module envelope_avg_unit #(
  parameter int SAMPLE_WIDTH = 24,
  parameter int LOG2_WINDOW  = 4
) (
  input logic               clk,
  input logic               rst_n,
  envelope_avg_unit_if.slave bus
);
  localparam int WINDOW    = 1 << LOG2_WINDOW;
  localparam int SUM_WIDTH = SAMPLE_WIDTH + LOG2_WINDOW;
  localparam logic [SAMPLE_WIDTH-1:0] MAG_MAX = {1'b0, {(SAMPLE_WIDTH-1){1'b1}}};
  localparam logic [SAMPLE_WIDTH-1:0] NEG_MIN = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};

  logic [SAMPLE_WIDTH-1:0] abs_in;
  logic [SAMPLE_WIDTH-1:0] abs_r;
  logic                    v1;
  logic [SAMPLE_WIDTH-1:0] win_buf [WINDOW];
  logic [SUM_WIDTH-1:0]    sum_q;
  logic [SUM_WIDTH-1:0]    new_sum;
  logic [LOG2_WINDOW-1:0]  wr_ptr;
  logic [LOG2_WINDOW:0]    fill_cnt;
  logic [SAMPLE_WIDTH-1:0] avg_q;
  logic                    env_valid_q;
  logic                    filled_q;

  // The most negative code has no positive twin, so it clamps to full scale.
  always_comb begin
    abs_in = bus.sample_in;
    if (bus.sample_in == NEG_MIN) begin
      abs_in = MAG_MAX;
    end else if (bus.sample_in[SAMPLE_WIDTH-1]) begin
      abs_in = -bus.sample_in;
    end
  end

  assign new_sum = sum_q + SUM_WIDTH'(abs_r) - SUM_WIDTH'(win_buf[wr_ptr]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      abs_r       <= '0;
      v1          <= 1'b0;
      sum_q       <= '0;
      wr_ptr      <= '0;
      fill_cnt    <= '0;
      avg_q       <= '0;
      env_valid_q <= 1'b0;
      filled_q    <= 1'b0;
      for (int i = 0; i < WINDOW; i++) begin
        win_buf[i] <= '0;
      end
    end else if (bus.clear) begin
      abs_r       <= '0;
      v1          <= 1'b0;
      sum_q       <= '0;
      wr_ptr      <= '0;
      fill_cnt    <= '0;
      avg_q       <= '0;
      env_valid_q <= 1'b0;
      filled_q    <= 1'b0;
      for (int i = 0; i < WINDOW; i++) begin
        win_buf[i] <= '0;
      end
    end else begin
      v1 <= bus.sample_valid;
      if (bus.sample_valid) begin
        abs_r <= abs_in;
      end
      env_valid_q <= v1;
      if (v1) begin
        // Oldest entry leaves the sum in the same cycle it is overwritten.
        sum_q           <= new_sum;
        win_buf[wr_ptr] <= abs_r;
        wr_ptr          <= wr_ptr + LOG2_WINDOW'(1);
        avg_q           <= new_sum[SUM_WIDTH-1:LOG2_WINDOW];
        if (!filled_q) begin
          fill_cnt <= fill_cnt + (LOG2_WINDOW+1)'(1);
        end
        if (fill_cnt == (LOG2_WINDOW+1)'(WINDOW - 1)) begin
          filled_q <= 1'b1;
        end
      end
    end
  end

  assign bus.env_avg   = avg_q;
  assign bus.env_valid = env_valid_q;
  assign bus.filled    = filled_q;
endmodule

// File: tb/tb_envelope_avg_unit.sv
// Bench for envelope_avg_unit: directed scenarios plus random traffic against a window-queue model.
module tb_envelope_avg_unit;
  localparam int SW   = 24;
  localparam int LOGW = 4;
  localparam int W    = 1 << LOGW;

  logic clk;
  logic rst_n;

  envelope_avg_unit_if #(.SAMPLE_WIDTH(SW)) bus ();

  envelope_avg_unit #(.SAMPLE_WIDTH(SW), .LOG2_WINDOW(LOGW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Model: the window is a queue of the last W magnitudes; the in-flight sample is held aside.
  int unsigned win_q[$];
  int          model_cnt;
  bit          pend_v;
  int unsigned pend_m;
  bit          exp_v;
  longint      exp_avg;
  bit          exp_f;

  task automatic check(input string tag, input longint obs, input longint exp);
    tests_run++;
    if (obs != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int unsigned mag(input int s);
    if (s == -(1 << (SW - 1))) return (1 << (SW - 1)) - 1;
    return (s < 0) ? -s : s;
  endfunction

  function automatic longint model_sum();
    longint t = 0;
    foreach (win_q[i]) t += win_q[i];
    return t;
  endfunction

  task automatic model_reset();
    win_q.delete();
    model_cnt = 0;
    pend_v    = 1'b0;
    pend_m    = 0;
    exp_v     = 1'b0;
    exp_avg   = 0;
    exp_f     = 1'b0;
  endtask

  task automatic model_edge(input bit v, input int s, input bit c);
    if (c) begin
      model_reset();
    end else begin
      exp_v = pend_v;
      if (pend_v) begin
        win_q.push_back(pend_m);
        if (win_q.size() > W) void'(win_q.pop_front());
        model_cnt++;
        exp_avg = model_sum() / W;
        exp_f   = (model_cnt >= W);
      end
      pend_v = v;
      pend_m = mag(s);
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, "_valid"}, longint'(bus.env_valid), longint'(exp_v));
    check({tag, "_avg"}, longint'(bus.env_avg), exp_avg);
    check({tag, "_filled"}, longint'(bus.filled), longint'(exp_f));
    check({tag, "_sum"}, longint'(dut.sum_q), model_sum());
  endtask

  // One clock: drive inputs, let the edge happen, then sample 1 ns later.
  task automatic step(input bit v, input int s, input bit c, input string tag);
    logic [31:0] raw;
    raw = s;
    bus.sample_valid = v;
    bus.sample_in    = raw[SW-1:0];
    bus.clear        = c;
    @(posedge clk);
    model_edge(v, s, c);
    #1;
    compare_all(tag);
  endtask

  initial begin
    int s;
    logic [SW-1:0] r;
    bus.sample_valid = 1'b0;
    bus.sample_in    = '0;
    bus.clear        = 1'b0;
    rst_n            = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    compare_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Constant positive samples ramp the average up.
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1_000_000, 1'b0, "t1");
      if (i == 1) check("t1_first_avg", longint'(bus.env_avg), 62_500);
    end
    step(1'b0, 0, 1'b0, "t1_tail");
    check("t1_last_avg", longint'(bus.env_avg), 1_000_000);
    check("t1_last_filled", longint'(bus.filled), 1);

    for (int i = 0; i < 16; i++) step(1'b1, -1_000_000, 1'b0, "t2_neg");
    for (int i = 0; i < 16; i++) step(1'b1, 0, 1'b0, "t2_zero");
    step(1'b0, 0, 1'b0, "t2_tail");
    step(1'b0, 0, 1'b0, "t2_tail");
    check("t2_end_avg", longint'(bus.env_avg), 0);

    // Most negative code saturates to full-scale magnitude.
    for (int i = 0; i < 16; i++) step(1'b1, -(1 << (SW - 1)), 1'b0, "t3_sat");
    step(1'b0, 0, 1'b0, "t3_tail");
    check("t3_sat_avg", longint'(bus.env_avg), 24'h7F_FFFF);
    step(1'b1, 0, 1'b0, "t3_17th");
    step(1'b0, 0, 1'b0, "t3_17th");
    check("t3_17th_avg", longint'(bus.env_avg), 7_864_319);

    step(1'b0, 0, 1'b1, "t4_clr");
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 160, 1'b0, "t4_gap");
      step(1'b0, 0, 1'b0, "t4_gap");
      check("t4_pulse_avg", longint'(bus.env_avg), 10 * (i + 1));
      step(1'b0, 0, 1'b0, "t4_gap");
      step(1'b0, 0, 1'b0, "t4_gap");
    end

    // Clear while a sample sits in the rectify stage.
    step(1'b1, 5_000, 1'b0, "t5_inflight");
    step(1'b0, 0, 1'b1, "t5_clear");
    check("t5_clr_valid", longint'(bus.env_valid), 0);
    check("t5_clr_filled", longint'(bus.filled), 0);
    step(1'b0, 0, 1'b0, "t5_idle");
    step(1'b1, 1_600, 1'b0, "t5_next");
    step(1'b0, 0, 1'b0, "t5_next");
    check("t5_next_avg", longint'(bus.env_avg), 100);

    // Asynchronous reset between edges with samples in flight.
    for (int i = 0; i < 20; i++) step(1'b1, 4_000 + i, 1'b0, "t6_pre");
    #2;
    rst_n = 1'b0;
    bus.sample_valid = 1'b0;
    #1;
    model_reset();
    compare_all("t6_async");
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 32, 1'b0, "t6_post");
    step(1'b0, 0, 1'b0, "t6_post");
    check("t6_post_avg", longint'(bus.env_avg), 2);
    check("t6_post_filled", longint'(bus.filled), 0);

    for (int i = 0; i < 400; i++) begin
      r = SW'($urandom);
      if ($urandom_range(0, 19) == 0) r = {1'b1, {(SW-1){1'b0}}};
      else if ($urandom_range(0, 19) == 0) r = {1'b0, {(SW-1){1'b1}}};
      s = $signed(r);
      step($urandom_range(0, 9) < 7, s, $urandom_range(0, 49) == 0, "rand");
    end
    step(1'b0, 0, 1'b0, "rand_tail");
    step(1'b0, 0, 1'b0, "rand_tail");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/envelope_avg_unit.md
Name: envelope_avg_unit

Overview:
- Produces the `env_avg` envelope value that the cutoff-frequency mapper consumes, i.e. the upstream end of that interface.
- Takes signed 24-bit audio samples with a valid strobe, full-wave rectifies them, and keeps a moving average over the last 2^LOG2_WINDOW samples.
- The average is held in a circular buffer plus a running sum.
- Output is registered, with a one-cycle `env_valid` pulse per accepted sample, so downstream cutoff logic updates once per audio sample.

Parameters:
- SAMPLE_WIDTH, 24, width of input samples and of env_avg.
- LOG2_WINDOW, 4, log2 of averaging window length (window = 16 samples); legal range 1..8.

Ports:
- clk  input  1  system clock, all logic rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- sample_in  input  SAMPLE_WIDTH  signed two's-complement audio sample.
- sample_valid  input  1  sample_in is valid this cycle; one sample accepted per high cycle.
- clear  input  1  synchronous flush of window, sum and pipeline.
- env_avg  output  SAMPLE_WIDTH  unsigned moving average of |sample| over the window.
- env_valid  output  1  one-cycle pulse: env_avg updated this cycle.
- filled  output  1  high once WINDOW samples have been accepted since reset/clear.

Behaviour:

Reset (rst_n low, asynchronous):
- env_avg=0, env_valid=0, filled=0.
- All buffer entries=0, running sum=0, write pointer=0, fill counter=0, stage-1 regs=0.

Stage 1 (edge where sample_valid=1):
- abs_r <= |sample_in|, v1 <= 1.
- Otherwise v1 <= 0.
- Saturation: the most negative input (-2^(SAMPLE_WIDTH-1), 0x800000) rectifies to 2^(SAMPLE_WIDTH-1)-1 (0x7FFFFF). All other values are exact magnitudes.

Stage 2 (edge where v1=1):
- new_sum = sum + abs_r - buf[wr_ptr]. sum <= new_sum.
- buf[wr_ptr] <= abs_r.
- wr_ptr <= wr_ptr+1, wrapping modulo WINDOW.
- env_avg <= new_sum >> LOG2_WINDOW (truncating).
- env_valid <= 1.
- When v1=0: env_valid <= 0 and env_avg holds.

Latency and throughput:
- sample_valid high at edge N gives env_valid high in the cycle following edge N+1 (2-cycle latency).
- sample_valid may stay high every cycle; one output pulse per accepted sample, no stalls, no backpressure.

Widths:
- Running sum is SAMPLE_WIDTH+LOG2_WINDOW bits unsigned and can never overflow (max WINDOW*(2^23-1)).
- env_avg always fits SAMPLE_WIDTH bits.

Warm-up:
- Before the window is full, unwritten entries are 0, so env_avg = sum/WINDOW (ramps up). No special scaling is applied.
- Fill counter saturates at WINDOW. filled goes high in the same cycle as the env_valid of the WINDOW-th sample and stays high.

Wrap-around:
- After WINDOW samples, the oldest entry is subtracted exactly as it is overwritten.
- The sum must always equal the sum of all buffer entries (bench checks this invariant).

clear (synchronous, highest priority):
- On an edge with clear=1: buffer, sum, wr_ptr, fill counter, v1, env_avg, env_valid and filled all go to 0.
- A sample presented with clear, or in flight in stage 1, is discarded.
- The first sample_valid after clear deasserts is treated as sample #1.

Reset mid-operation:
- Asynchronous clear of all state, identical to power-on.
- No env_valid is produced for in-flight samples.

No combinational path from inputs to outputs.

Test Plan:
1. Reset, then 16 consecutive valid samples of +1_000_000 -> env_valid pulses 16 times. First env_avg=62_500, 16th env_avg=1_000_000 with filled=1 on that same cycle.
2. Continue with 16 samples of -1_000_000 -> env_avg stays 1_000_000 on every pulse (rectification). Then 16 samples of 0 -> env_avg steps down by 62_500 per pulse to 0.
3. 16 samples of 0x800000 -> final env_avg=0x7FFFFF (saturation), no sum overflow. Then 17th sample 0 -> env_avg=(15*0x7FFFFF)>>4=7_864_319.
4. Valid gapped (1 cycle on, 3 off) with value 160 -> each env_valid exactly 2 cycles after its sample_valid; env_avg 10, 20, ... 160; env_avg holds between pulses.
5. After filled=1, assert clear for 1 cycle while a sample is in stage 1 -> no env_valid for that sample, env_avg=0, filled=0. Next sample 1_600 -> env_avg=100.
6. Drop rst_n asynchronously mid-stream between clock edges -> outputs are 0 immediately. After release, one sample of 32 -> env_avg=2, filled=0.
